multicycle_ctrl: RTL

Multi-cycle control sequencer for the MIPS-style datapath. It steps each instruction through fetch, decode, execute, memory and writeback, one state per clock. In each state it drives the mux selects, write enables and ALU operation code. It sits between the instruction register (which supplies OP/Func) and the datapath/memory, and stalls on a memory ready handshake.

---
 rtl/multicycle_ctrl_pkg.sv | 45 ++++
 rtl/multicycle_ctrl_if.sv | 40 ++++
 rtl/alu_func_decode.sv | 25 ++
 rtl/multicycle_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared control definitions for the multi-cycle sequencer:
// state encoding, opcode/Func constants and ALU operation codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST       = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXEC_R    = 4'd3,
        S_WB_R      = 4'd4,
        S_EXEC_ADDR = 4'd5,
        S_MEM_RD    = 4'd6,
        S_WB_MEM    = 4'd7,
        S_MEM_WR    = 4'd8,
        S_BRANCH    = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_NOP = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_NOR = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic op_known(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) ||
               (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the sequencer (master) and the
// datapath/instruction register/memory side (slave).
interface multicycle_ctrl_if #(
    parameter int CNT_W = 16
);

    logic [5:0]       OP;
    logic [5:0]       Func;
    logic             Zero;
    logic             Memready;
    logic             PCwe;
    logic             PCsrc;
    logic             IRwe;
    logic             Memre;
    logic             Memwe;
    logic             Memmux;
    logic             Alumux;
    logic             Regmux;
    logic             Regdst;
    logic             Regwe;
    logic [2:0]       ALUctrl;
    logic             Illegal;
    logic             Retire;
    logic [CNT_W-1:0] Retcnt;

    modport master (
        input  OP, Func, Zero, Memready,
        output PCwe, PCsrc, IRwe, Memre, Memwe,
        output Memmux, Alumux, Regmux, Regdst, Regwe,
        output ALUctrl, Illegal, Retire, Retcnt
    );

    modport slave (
        output OP, Func, Zero, Memready,
        input  PCwe, PCsrc, IRwe, Memre, Memwe,
        input  Memmux, Alumux, Regmux, Regdst, Regwe,
        input  ALUctrl, Illegal, Retire, Retcnt
    );

endinterface

// File: rtl/alu_func_decode.sv
// R-type Func field to ALU operation code; shared with the
// single-cycle decoder.
module alu_func_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] func,
    output logic [2:0] alu
);

    // pure lookup, unlisted Func values become a no-op
    always_comb begin
        alu = ALU_NOP;
        unique case (1'b1)
            (func == F_ADD): alu = ALU_ADD;
            (func == F_SUB): alu = ALU_SUB;
            (func == F_AND): alu = ALU_AND;
            (func == F_OR):  alu = ALU_OR;
            (func == F_XOR): alu = ALU_XOR;
            (func == F_NOR): alu = ALU_NOR;
            (func == F_SLT): alu = ALU_SLT;
            default:         alu = ALU_NOP;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: fetch/decode/execute/memory/writeback,
// one state per clock, stalling on the memory ready handshake.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter bit ILL_TRAP = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_if.master   bus
);

    state_t           state;
    state_t           nxt;
    logic [2:0]       func_alu;
    logic [2:0]       alu_d;
    logic             op_r;
    logic             op_mem;
    logic             op_beq;
    logic             op_bad;
    logic             retire_d;
    logic             illegal_d;

    logic             fetch_q;
    logic             branch_q;
    logic             memre_q;
    logic             memwe_q;
    logic             memmux_q;
    logic             alumux_q;
    logic             regmux_q;
    logic             regdst_q;
    logic             regwe_q;
    logic [2:0]       alu_q;
    logic             is_sw_q;
    logic             retire_q;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;

    alu_func_decode u_fdec (
        .func (bus.Func),
        .alu  (func_alu)
    );

    // opcode classification for the decode step
    always_comb begin
        op_r   = (bus.OP == OP_RTYPE);
        op_mem = (bus.OP == OP_LW) || (bus.OP == OP_SW);
        op_beq = (bus.OP == OP_BEQ);
        op_bad = !op_known(bus.OP);
    end

    // next-state selection
    always_comb begin
        nxt = S_FETCH;
        case (state)
            S_RST:       nxt = S_FETCH;
            S_FETCH:     nxt = bus.Memready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (1'b1)
                    op_r:    nxt = S_EXEC_R;
                    op_mem:  nxt = S_EXEC_ADDR;
                    op_beq:  nxt = S_BRANCH;
                    default: nxt = S_FETCH;
                endcase
            end
            S_EXEC_R:    nxt = S_WB_R;
            S_WB_R:      nxt = S_FETCH;
            S_EXEC_ADDR: nxt = is_sw_q ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:    nxt = bus.Memready ? S_WB_MEM : S_MEM_RD;
            S_WB_MEM:    nxt = S_FETCH;
            S_MEM_WR:    nxt = bus.Memready ? S_FETCH : S_MEM_WR;
            S_BRANCH:    nxt = S_FETCH;
            default:     nxt = S_FETCH;
        endcase
    end

    // ALU code that the upcoming state will present
    always_comb begin
        alu_d = ALU_NOP;
        case (nxt)
            S_FETCH:     alu_d = ALU_ADD;
            S_DECODE:    alu_d = ALU_ADD;
            S_EXEC_ADDR: alu_d = ALU_ADD;
            S_EXEC_R:    alu_d = func_alu;
            S_BRANCH:    alu_d = ALU_SUB;
            default:     alu_d = ALU_NOP;
        endcase
    end

    // completion events, shown as pulses in the following cycle
    always_comb begin
        retire_d  = (state == S_WB_R) ||
                    (state == S_WB_MEM) ||
                    (state == S_BRANCH) ||
                    ((state == S_MEM_WR) && bus.Memready) ||
                    ((state == S_DECODE) && op_bad && !ILL_TRAP);
        illegal_d = (state == S_DECODE) && op_bad && ILL_TRAP;
    end

    // state register with Moore outputs registered from next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RST;
            fetch_q   <= 1'b0;
            branch_q  <= 1'b0;
            memre_q   <= 1'b0;
            memwe_q   <= 1'b0;
            memmux_q  <= 1'b0;
            alumux_q  <= 1'b0;
            regmux_q  <= 1'b0;
            regdst_q  <= 1'b0;
            regwe_q   <= 1'b0;
            alu_q     <= ALU_NOP;
            is_sw_q   <= 1'b0;
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state     <= nxt;
            fetch_q   <= (nxt == S_FETCH);
            branch_q  <= (nxt == S_BRANCH);
            memre_q   <= (nxt == S_FETCH) || (nxt == S_MEM_RD);
            memwe_q   <= (nxt == S_MEM_WR);
            memmux_q  <= (nxt == S_MEM_RD) || (nxt == S_MEM_WR);
            alumux_q  <= (nxt == S_DECODE) || (nxt == S_EXEC_ADDR);
            regmux_q  <= (nxt == S_WB_MEM);
            regdst_q  <= (nxt == S_WB_R);
            regwe_q   <= (nxt == S_WB_R) || (nxt == S_WB_MEM);
            alu_q     <= alu_d;
            if (state == S_DECODE)
                is_sw_q <= (bus.OP == OP_SW);
            retire_q  <= retire_d;
            illegal_q <= illegal_d;
            if (retire_d)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // IR/PC loads qualify the fetch window with the live handshake;
    // the branch PC write qualifies with the live zero flag
    assign bus.IRwe    = fetch_q & bus.Memready;
    assign bus.PCwe    = (fetch_q & bus.Memready) |
                         (branch_q & bus.Zero);
    assign bus.PCsrc   = branch_q;
    assign bus.Memre   = memre_q;
    assign bus.Memwe   = memwe_q;
    assign bus.Memmux  = memmux_q;
    assign bus.Alumux  = alumux_q;
    assign bus.Regmux  = regmux_q;
    assign bus.Regdst  = regdst_q;
    assign bus.Regwe   = regwe_q;
    assign bus.ALUctrl = alu_q;
    assign bus.Retire  = retire_q;
    assign bus.Illegal = illegal_q;
    assign bus.Retcnt  = cnt_q;

endmodule
